// File: rtl/aes_128_key_pkg.sv
// Shared sizes and types for the AES-128 round-key store.
package aes_128_key_pkg;
  localparam int KEY_WORD_W    = 64;
  localparam int NUM_ROUNDS    = 11;
  localparam int WORDS_PER_SET = 2 * NUM_ROUNDS;

  typedef logic [127:0]          round_key_t;
  typedef logic [KEY_WORD_W-1:0] key_word_t;
  typedef logic [4:0]            key_ptr_t;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } store_state_t;

  localparam key_ptr_t LAST_PTR = key_ptr_t'(WORDS_PER_SET - 1);
endpackage

// File: rtl/aes_128_key_store_if.sv
// Key-write, switch and round-key read bundle between key port and round stages.
interface aes_128_key_store_if;
  import aes_128_key_pkg::*;

  logic       en_wr;
  key_word_t  key_round_wr;
  logic       switch_key;
  logic [3:0] rd_round;
  round_key_t rd_key;
  logic       key_idx;
  logic       key_valid;
  logic       shadow_full;
  logic       switch_err_pulse;

  modport master (
    output en_wr, key_round_wr, switch_key, rd_round,
    input  rd_key, key_idx, key_valid, shadow_full, switch_err_pulse
  );

  modport slave (
    input  en_wr, key_round_wr, switch_key, rd_round,
    output rd_key, key_idx, key_valid, shadow_full, switch_err_pulse
  );
endinterface

// File: rtl/aes_128_key_bank.sv
// One 22 x 64 key set: single write port, combinational 128-bit round read.
module aes_128_key_bank
  import aes_128_key_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  key_ptr_t   waddr,
  input  key_word_t  wdata,
  input  logic [3:0] r,
  output round_key_t rd
);

  key_word_t mem [WORDS_PER_SET];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Round r lives in words 2r (low half) and 2r+1 (high half).
  always_comb begin
    rd = '0;
    if (r < 4'(NUM_ROUNDS)) rd = {mem[{r, 1'b1}], mem[{r, 1'b0}]};
  end

endmodule

// File: rtl/aes_128_key_store.sv
// Double-buffered round-key store: writes fill the shadow set, switch_key swaps.
module aes_128_key_store
  import aes_128_key_pkg::*;
(
  input  logic clk,
  input  logic kill,
  aes_128_key_store_if.slave bus
);

  store_state_t state_q, state_d;
  key_ptr_t     wp_q;
  logic         full_q;
  logic         key_idx_q;
  logic         err_p1;
  round_key_t   rd_key_p1;
  round_key_t   rd0, rd1;
  logic         switch_ok, switch_rej;
  logic         we0, we1;
  key_ptr_t     waddr;

  assign switch_ok  = bus.switch_key && full_q && !bus.en_wr;
  assign switch_rej = bus.switch_key && !switch_ok;

  // Shadow is the bank not selected by key_idx; a write to a full shadow restarts at 0.
  assign we0   = bus.en_wr && !kill &&  key_idx_q;
  assign we1   = bus.en_wr && !kill && !key_idx_q;
  assign waddr = full_q ? '0 : wp_q;

  aes_128_key_bank u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (waddr),
    .wdata (bus.key_round_wr),
    .r     (bus.rd_round),
    .rd    (rd0)
  );

  aes_128_key_bank u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (waddr),
    .wdata (bus.key_round_wr),
    .r     (bus.rd_round),
    .rd    (rd1)
  );

  always_ff @(posedge clk) begin
    if (kill) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (switch_ok) state_d = ST_ACTIVE;
  end

  // Stage p1: registered read of the active bank plus control updates.
  always_ff @(posedge clk) begin
    if (kill) begin
      wp_q      <= '0;
      full_q    <= 1'b0;
      key_idx_q <= 1'b0;
      err_p1    <= 1'b0;
      rd_key_p1 <= '0;
    end else begin
      err_p1    <= switch_rej;
      rd_key_p1 <= (state_q == ST_ACTIVE) ? (key_idx_q ? rd1 : rd0) : '0;
      if (bus.en_wr) begin
        if (full_q) begin
          wp_q   <= key_ptr_t'(1);
          full_q <= 1'b0;
        end else if (wp_q == LAST_PTR) begin
          wp_q   <= '0;
          full_q <= 1'b1;
        end else begin
          wp_q <= wp_q + key_ptr_t'(1);
        end
      end else if (switch_ok) begin
        wp_q      <= '0;
        full_q    <= 1'b0;
        key_idx_q <= ~key_idx_q;
      end
    end
  end

  assign bus.rd_key           = rd_key_p1;
  assign bus.key_idx          = key_idx_q;
  assign bus.key_valid        = (state_q == ST_ACTIVE);
  assign bus.shadow_full      = full_q;
  assign bus.switch_err_pulse = err_p1;

endmodule

// File: tb/tb_aes_128_key_store.sv
// Self-checking bench for aes_128_key_store: directed corner cases plus random traffic vs. a model.
module tb_aes_128_key_store;
  import aes_128_key_pkg::*;

  logic clk = 1'b0;
  logic kill;
  always #5 clk = ~clk;

  aes_128_key_store_if kif();

  aes_128_key_store dut (
    .clk  (clk),
    .kill (kill),
    .bus  (kif.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: two word arrays plus the visible control flags.
  key_word_t  mbuf [2][WORDS_PER_SET];
  int         m_wp;
  bit         m_full, m_idx, m_valid, m_err;
  round_key_t m_rd;

  logic [127:0] fips [NUM_ROUNDS];
  key_word_t    setw [WORDS_PER_SET];

  typedef struct {
    logic [3:0] r;
    round_key_t exp;
    string      name;
  } rd_vec_t;
  rd_vec_t tbl [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic round_key_t brev(input logic [127:0] x);
    round_key_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic key_word_t fips_word(input int i);
    round_key_t k;
    k = brev(fips[i/2]);
    return (i % 2) ? k[127:64] : k[63:0];
  endfunction

  // Advance one clock, update the model from the inputs it sampled, compare all outputs.
  task automatic tick();
    bit         k, en, sw, acc;
    key_word_t  w;
    int         r;
    k  = kill;
    en = kif.en_wr;
    sw = kif.switch_key;
    w  = kif.key_round_wr;
    r  = int'(kif.rd_round);
    @(posedge clk);
    if (k) begin
      m_wp = 0; m_full = 0; m_idx = 0; m_valid = 0; m_rd = '0; m_err = 0;
    end else begin
      if (m_valid && r < NUM_ROUNDS) m_rd = {mbuf[m_idx][2*r+1], mbuf[m_idx][2*r]};
      else                           m_rd = '0;
      acc   = sw && m_full && !en;
      m_err = sw && !acc;
      if (en) begin
        if (m_full) begin
          mbuf[!m_idx][0] = w; m_wp = 1; m_full = 0;
        end else begin
          mbuf[!m_idx][m_wp] = w;
          if (m_wp == WORDS_PER_SET - 1) begin m_wp = 0; m_full = 1; end
          else m_wp++;
        end
      end
      if (acc) begin
        m_idx = !m_idx; m_full = 0; m_valid = 1; m_wp = 0;
      end
    end
    #1;
    chk("model key_idx",     128'(kif.key_idx),          128'(m_idx));
    chk("model key_valid",   128'(kif.key_valid),        128'(m_valid));
    chk("model shadow_full", 128'(kif.shadow_full),      128'(m_full));
    chk("model err_pulse",   128'(kif.switch_err_pulse), 128'(m_err));
    chk("model rd_key",      kif.rd_key,                 m_rd);
  endtask

  task automatic write_word(input key_word_t w, input bit sw);
    kif.en_wr = 1'b1; kif.key_round_wr = w; kif.switch_key = sw;
    tick();
    kif.en_wr = 1'b0; kif.switch_key = 1'b0;
  endtask

  task automatic do_switch();
    kif.switch_key = 1'b1;
    tick();
    kif.switch_key = 1'b0;
  endtask

  task automatic load_fips();
    for (int i = 0; i < WORDS_PER_SET; i++) write_word(fips_word(i), 1'b0);
  endtask

  initial begin
    fips[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    fips[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    fips[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    fips[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    fips[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    fips[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    fips[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    fips[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    fips[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    fips[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    fips[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    tbl[0] = '{4'd0,  128'h0f0e0d0c0b0a09080706050403020100, "read round 0"};
    tbl[1] = '{4'd5,  128'haa22f6ad57aff350eb9d9fa9e8a3aa3c, "read round 5"};
    tbl[2] = '{4'd10, 128'hc5302b4d8ba707f3174a94e37f1d1113, "read round 10"};
    tbl[3] = '{4'd11, 128'h0,                                "read round 11"};
    tbl[4] = '{4'd15, 128'h0,                                "read round 15"};
    tbl[5] = '{4'd1,  128'hfe76abd6f178a6dafa72afd2fd74aad6, "read round 1"};

    kill = 1'b1;
    kif.en_wr = 1'b0; kif.key_round_wr = '0; kif.switch_key = 1'b0; kif.rd_round = 4'd0;
    m_wp = 0; m_full = 0; m_idx = 0; m_valid = 0; m_err = 0; m_rd = '0;
    tick();
    tick();
    chk("reset key_idx",     128'(kif.key_idx),          128'h0);
    chk("reset key_valid",   128'(kif.key_valid),        128'h0);
    chk("reset shadow_full", 128'(kif.shadow_full),      128'h0);
    chk("reset err_pulse",   128'(kif.switch_err_pulse), 128'h0);
    chk("reset rd_key",      kif.rd_key,                 128'h0);
    kill = 1'b0;

    // Empty read before any switch.
    kif.rd_round = 4'd3;
    tick();
    chk("empty read", kif.rd_key, 128'h0);

    // Basic load and switch with FIPS-197 keys.
    load_fips();
    chk("full after 22 words", 128'(kif.shadow_full), 128'h1);
    do_switch();
    chk("switch key_idx",   128'(kif.key_idx),   128'h1);
    chk("switch key_valid", 128'(kif.key_valid), 128'h1);
    chk("switch full clr",  128'(kif.shadow_full), 128'h0);
    for (int i = 0; i < 6; i++) begin
      kif.rd_round = tbl[i].r;
      tick();
      chk(tbl[i].name, kif.rd_key, tbl[i].exp);
    end

    // Premature switch, then a switch coinciding with the 22nd word, then an accepted one.
    for (int i = 0; i < WORDS_PER_SET; i++) setw[i] = {$urandom, $urandom};
    for (int i = 0; i < WORDS_PER_SET - 1; i++) write_word(setw[i], 1'b0);
    do_switch();
    chk("premature err",     128'(kif.switch_err_pulse), 128'h1);
    chk("premature key_idx", 128'(kif.key_idx),          128'h1);
    chk("premature full",    128'(kif.shadow_full),      128'h0);
    tick();
    chk("err one cycle", 128'(kif.switch_err_pulse), 128'h0);
    write_word(setw[WORDS_PER_SET-1], 1'b1);
    chk("coincide err",     128'(kif.switch_err_pulse), 128'h1);
    chk("coincide key_idx", 128'(kif.key_idx),          128'h1);
    chk("coincide full",    128'(kif.shadow_full),      128'h1);
    do_switch();
    chk("late switch key_idx", 128'(kif.key_idx),          128'h0);
    chk("late switch err",     128'(kif.switch_err_pulse), 128'h0);
    kif.rd_round = 4'd7;
    tick();
    chk("set B round 7", kif.rd_key, {setw[15], setw[14]});

    // Reload during use: FIPS active, new set written with gaps while reading round 5.
    load_fips();
    do_switch();
    kif.rd_round = 4'd5;
    tick();
    for (int i = 0; i < WORDS_PER_SET; i++) setw[i] = {$urandom, $urandom};
    for (int i = 0; i < WORDS_PER_SET; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        tick();
        chk("reload gap read", kif.rd_key, tbl[1].exp);
      end
      write_word(setw[i], 1'b0);
      chk("reload write read", kif.rd_key, tbl[1].exp);
    end
    do_switch();
    chk("read at switch edge", kif.rd_key, tbl[1].exp);
    tick();
    chk("read after switch", kif.rd_key, {setw[11], setw[10]});

    // Reset mid-load discards the partial set.
    for (int i = 0; i < 10; i++) write_word({$urandom, $urandom}, 1'b0);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill key_valid", 128'(kif.key_valid), 128'h0);
    for (int i = 0; i < WORDS_PER_SET; i++) setw[i] = {$urandom, $urandom};
    for (int i = 0; i < WORDS_PER_SET; i++) write_word(setw[i], 1'b0);
    do_switch();
    chk("post-kill key_idx", 128'(kif.key_idx), 128'h1);
    for (int r = 0; r < NUM_ROUNDS; r++) begin
      kif.rd_round = 4'(r);
      tick();
      chk("post-kill round", kif.rd_key, {setw[2*r+1], setw[2*r]});
    end

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      kif.en_wr        = ($urandom_range(0, 9) < 6);
      kif.key_round_wr = {$urandom, $urandom};
      kif.switch_key   = ($urandom_range(0, 9) < 2);
      kif.rd_round     = 4'($urandom_range(0, 15));
      kill             = ($urandom_range(0, 299) == 0);
      tick();
    end
    kill = 1'b0;
    kif.en_wr = 1'b0;
    kif.switch_key = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
